// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: drives rows one-hot, samples columns once per row
// period, classifies each full scan frame (none / single / multi) and
// debounces press and release across frames.
module keypad_scan_debounce #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 20,
  localparam int CODE_W  = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [COLS-1:0]   col,
  output logic [ROWS-1:0]   fil,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_release,
  output logic              key_held,
  output logic              multi_err
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int ROW_W = $clog2(ROWS);
  localparam int CNT_W = $clog2(DEBOUNCE+1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV-1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS-1);
  localparam logic [CNT_W-1:0] DEB_CNT  = CNT_W'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROWS-1:0]   fil_q, fil_d;
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [CODE_W-1:0] acc_code_q, acc_code_d;
  state_t            state_q, state_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  frm_cnt_q, frm_cnt_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_release_q, key_release_d;
  logic              multi_err_q, multi_err_d;

  logic              tc;
  logic              frame_end;
  logic [1:0]        row_ones;
  logic              row_hit;
  logic [CODE_W-1:0] row_col;
  logic [CODE_W-1:0] row_base;
  logic [2:0]        sum_ones;
  logic [1:0]        frm_ones;
  logic [CODE_W-1:0] frm_code;
  logic [CNT_W-1:0]  frm_inc;
  logic              is_none, is_single, is_multi, same_key;

  // Row period divider and one-hot row rotation
  always_comb begin
    div_d     = div_q + DIV_W'(1);
    row_d     = row_q;
    fil_d     = fil_q;
    tc        = (div_q == DIV_LAST);
    frame_end = tc && (row_q == ROW_LAST);
    if (tc) begin
      div_d = '0;
      fil_d = {fil_q[ROWS-2:0], fil_q[ROWS-1]};
      row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
    end
  end

  // Closed-switch count (saturating at 2) and lowest closed column of this row
  always_comb begin
    row_ones = 2'd0;
    row_hit  = 1'b0;
    row_col  = '0;
    row_base = CODE_W'(32'(row_q) * COLS);
    for (int i = 0; i < COLS; i++) begin
      if (col[i]) begin
        if (row_ones != 2'd2) row_ones = row_ones + 2'd1;
        if (!row_hit) begin
          row_hit = 1'b1;
          row_col = CODE_W'(i);
        end
      end
    end
  end

  // Frame accumulator: running count and first code, cleared at frame end
  always_comb begin
    sum_ones   = {1'b0, acc_cnt_q} + {1'b0, row_ones};
    frm_ones   = (sum_ones >= 3'd2) ? 2'd2 : sum_ones[1:0];
    frm_code   = (acc_cnt_q == 2'd0 && row_hit) ? row_base + row_col : acc_code_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (tc) begin
      if (frame_end) begin
        acc_cnt_d  = '0;
        acc_code_d = '0;
      end else begin
        acc_cnt_d  = frm_ones;
        acc_code_d = frm_code;
      end
    end
  end

  // Debounce FSM next state and event pulses, evaluated only at frame end
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    frm_cnt_d     = frm_cnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    multi_err_d   = 1'b0;
    frm_inc       = (frm_cnt_q == DEB_CNT) ? frm_cnt_q : frm_cnt_q + CNT_W'(1);
    is_none       = (frm_ones == 2'd0);
    is_single     = (frm_ones == 2'd1);
    is_multi      = (frm_ones == 2'd2);
    same_key      = (frm_code == cand_q);
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d    = frm_code;
            frm_cnt_d = CNT_W'(1);
            if (DEBOUNCE == 1) begin
              state_d     = HELD;
              key_code_d  = frm_code;
              key_valid_d = 1'b1;
            end else begin
              state_d = PRESS_WAIT;
            end
          end else begin
            multi_err_d = is_multi;
          end
        end
        PRESS_WAIT: begin
          if (is_single && same_key) begin
            frm_cnt_d = frm_inc;
            if (frm_inc == DEB_CNT) begin
              state_d     = HELD;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
            end
          end else begin
            state_d     = IDLE;
            frm_cnt_d   = '0;
            multi_err_d = is_multi;
          end
        end
        HELD: begin
          if (is_none) begin
            frm_cnt_d = CNT_W'(1);
            if (DEBOUNCE == 1) begin
              state_d       = IDLE;
              frm_cnt_d     = '0;
              key_release_d = 1'b1;
            end else begin
              state_d = RELEASE_WAIT;
            end
          end else begin
            // a different single key while held is ignored: no rollover
            multi_err_d = is_multi;
          end
        end
        RELEASE_WAIT: begin
          if (is_none) begin
            frm_cnt_d = frm_inc;
            if (frm_inc == DEB_CNT) begin
              state_d       = IDLE;
              frm_cnt_d     = '0;
              key_release_d = 1'b1;
            end
          end else begin
            state_d     = HELD;
            frm_cnt_d   = '0;
            multi_err_d = is_multi;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q         <= '0;
      row_q         <= '0;
      fil_q         <= ROWS'(1);
      acc_cnt_q     <= '0;
      acc_code_q    <= '0;
      state_q       <= IDLE;
      cand_q        <= '0;
      frm_cnt_q     <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      multi_err_q   <= 1'b0;
    end else begin
      div_q         <= div_d;
      row_q         <= row_d;
      fil_q         <= fil_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_code_q    <= acc_code_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      frm_cnt_q     <= frm_cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
      multi_err_q   <= multi_err_d;
    end
  end

  assign fil         = fil_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_release = key_release_q;
  assign multi_err   = multi_err_q;
  assign key_held    = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Parametrised matrix-keypad scanner for the calculator front end. It drives the row lines one-hot and samples the column lines once per row period. It classifies each complete scan frame as no key, one key or several keys, and debounces across frames with a four-state FSM. It emits one-cycle press and release events with a binary key code, and sits between the keypad pins and the key-to-segment conversion and display logic.

## Interface
- ROWS, 4, number of row lines driven (≥2)
- COLS, 4, number of column lines sampled (≥2)
- SCAN_DIV, 50000, clk cycles per row period (≥2)
- DEBOUNCE, 20, consecutive identical frames required to accept a press or release (≥1)
- CODE_W, $clog2(ROWS*COLS), key code width (derived; not overridden)
- clk  in  1  system clock; single clock domain
- rst_n  in  1  synchronous reset, active-low
- col  in  COLS  column sense lines, active-high (1 = switch closed on the driven row); already synchronised externally
- fil  out  ROWS  row drive, one-hot active-high
- key_code  out  CODE_W  code of the accepted key, row*COLS + column index; holds its value until the next accepted press
- key_valid  out  1  one-cycle pulse on press acceptance
- key_release  out  1  one-cycle pulse on release acceptance
- key_held  out  1  level; high while the FSM is in HELD or RELEASE_WAIT
- multi_err  out  1  one-cycle pulse when a frame contains more than one closed switch

## Operation
- Row scan:
  - A divider counts 0..SCAN_DIV-1; at the terminal count, fil rotates to the next row.
  - After row ROWS-1 the scan wraps to row 0.
  - col is sampled on the terminal-count cycle of each row period, which gives settling time.
- Frame accumulation:
  - A frame covers rows 0..ROWS-1.
  - The block accumulates the number of closed switches in the frame, saturating at 2.
  - It also records the code of the first closed switch found, scanning lowest row first, then lowest column.
- Frame classification happens at the sample of row ROWS-1: NONE (count 0), SINGLE(c) (count 1) or MULTI (count ≥2).
- FSM states and transitions (all evaluated at frame end; frm_cnt counts agreeing frames):
  - IDLE:
    - SINGLE(c): cand=c, frm_cnt=1. If DEBOUNCE==1, go directly to HELD with acceptance; otherwise go to PRESS_WAIT.
    - NONE: stay in IDLE.
    - MULTI: stay in IDLE and pulse multi_err.
  - PRESS_WAIT:
    - SINGLE(cand): frm_cnt++. When frm_cnt reaches DEBOUNCE, go to HELD, set key_code=cand and pulse key_valid.
    - SINGLE(other) or NONE: go to IDLE, frm_cnt=0.
    - MULTI: go to IDLE and pulse multi_err.
  - HELD:
    - NONE: go to RELEASE_WAIT, frm_cnt=1. If DEBOUNCE==1, go directly to IDLE and pulse key_release.
    - SINGLE(cand): stay in HELD.
    - SINGLE(other): stay in HELD; the frame is ignored, with no rollover.
    - MULTI: stay in HELD and pulse multi_err.
  - RELEASE_WAIT:
    - NONE: frm_cnt++. When frm_cnt reaches DEBOUNCE, go to IDLE and pulse key_release.
    - Any frame containing a key: return to HELD with no event; a MULTI frame also pulses multi_err.
- frm_cnt width is $clog2(DEBOUNCE+1). It saturates and never wraps.
- key_valid and key_release never assert in the same cycle.
- At most one of key_valid, key_release and multi_err asserts per frame end.

## Timing
- Reset values (rst_n=0 sampled on a clk edge):
  - fil = 1 (row 0), and the divider resets to 0.
  - The frame accumulator is cleared.
  - The FSM is in IDLE with frm_cnt = 0.
  - key_code = 0, key_valid = 0, key_release = 0, key_held = 0, multi_err = 0.
- Reset asserted mid-frame or mid-press discards all state. No release event is emitted, and scanning restarts at row 0 on the first cycle after rst_n rises.
- Frame period is ROWS*SCAN_DIV cycles.
- The first frame end after reset is at cycle ROWS*SCAN_DIV-1; event outputs are registered one cycle later.
- Press latency:
  - Event pulses appear one clk cycle after the frame-end sample.
  - key_valid occurs DEBOUNCE frame ends after the first frame that sees the key. For example, if the key is closed from reset, key_valid asserts at cycle DEBOUNCE*ROWS*SCAN_DIV.
- key_code updates in the same cycle that key_valid rises.
- key_held rises with key_valid and falls with key_release.

## Test plan
All scenarios use ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3; one frame is 16 cycles.
- Reset: hold rst_n=0 for 5 cycles, col=0 -> fil=0001 and all outputs 0. After release, fil steps 0001→0010→0100→1000→0001 every 4 cycles.
- Clean press: close row 2 col 1 from reset -> key_valid single pulse at cycle 48 with key_code=9 and key_held=1. Hold for 10 frames -> no further key_valid.
- Bounce: key 9 present in frames 1 and 2, absent in frame 3, present in frames 4-6 -> no pulse through frame 3, then key_valid at the end of frame 6 with key_code=9.
- Release and re-press:
  - After acceptance, open the key -> key_release one pulse 3 frame ends later and key_held=0.
  - Open the key for only 2 frames, then re-close -> no key_release, and key_held stays 1.
- Multi-key: close code 0 and code 15 together from IDLE -> multi_err pulse at every frame end and no key_valid. Then drop code 15 -> key_valid with key_code=0 after 3 frames.
- Reset mid-hold: key 9 is held; assert rst_n=0 for 1 cycle -> key_held=0, key_release never pulses, fil=0001, and key_valid repeats 48 cycles after reset.
